ifetch_unit: RTL and testbench

Instruction fetch unit that produces the opcode/instruction stream consumed by the main decoder and datapath.
- Holds the fetch PC and issues single-outstanding reads to instruction memory.
- Buffers returned words with their PC+4 in a small queue and presents them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute: flushes the queue and squashes any in-flight read.

---
 rtl/ifetch_unit.sv | 184 ++++++++++++++++++
 tb/tb_ifetch_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//
// Purpose:
//   Instruction fetch front end. It holds the fetch PC and issues one
//   outstanding read at a time to instruction memory. Returned words are
//   buffered together with their PC+4 in a small queue. The queue is
//   presented to decode over a valid/ready handshake. A redirect from
//   execute flushes the queue and squashes any read that is still in flight.
//
// Parameters:
//   RESET_PC     fetch PC loaded on reset
//   QDEPTH       instruction queue depth (power of two, >= 2)
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   imem_req     read request, high while a transaction is pending
//   imem_addr    read address (current fetch PC)
//   imem_rvalid  read data valid, ends the current transaction
//   imem_rdata   read data
//   redirect     branch/jump taken this cycle
//   redirect_pc  redirect target
//   dec_valid    queue head valid
//   dec_ready    decode accepts the head
//   dec_instr    head instruction word
//   dec_pcplus4  head PC+4
//   misalign     sticky misaligned-redirect flag
//
// Build option:
//   IFETCH_ALIGN_CHECK_EN  When defined, a misaligned redirect target sets
//                          misalign. Fetch then parks in HALT until reset.
//                          When not defined, the target is force-aligned
//                          and misalign stays 0.
// ---------------------------------------------------------------------------
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pcplus4,
  output logic        misalign
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

`ifdef IFETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DROP, ST_HALT} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DROP} state_e;
`endif

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     instr_q [QDEPTH];
  logic [31:0]     pc4_q   [QDEPTH];
  logic            push, pop;
  logic [31:0]     target_pc;
  logic            halt_pend;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  logic target_bad;
  assign target_pc  = redirect_pc;
  assign target_bad = |redirect_pc[1:0];
  // Halt as soon as fetch is quiet: immediately if no read is in flight,
  // otherwise once the squashed read has drained through DROP.
  assign halt_pend  = misalign_q | (redirect & target_bad);
  assign misalign   = misalign_q;
`else
  logic unused_lowbits;
  assign target_pc      = {redirect_pc[31:2], 2'b00};
  assign halt_pend      = 1'b0;
  assign misalign       = 1'b0;
  assign unused_lowbits = ^redirect_pc[1:0];
`endif

  assign imem_req    = (state_q == ST_WAIT);
  assign imem_addr   = fetch_pc_q;
  assign dec_valid   = (count_q != '0);
  assign dec_instr   = instr_q[rd_ptr_q];
  assign dec_pcplus4 = pc4_q[rd_ptr_q];

  // A redirect cancels any pop in the same cycle.
  assign pop = dec_valid & dec_ready & ~redirect;

  // Next-state logic. Redirect overrides queue and FSM activity.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    push       = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    misalign_d = misalign_q | (redirect & target_bad);
`endif

    if (redirect) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = target_pc;
      unique case (state_q)
        ST_WAIT: state_d = imem_rvalid ? ST_IDLE : ST_DROP;
        ST_DROP: state_d = imem_rvalid ? ST_IDLE : ST_DROP;
        default: state_d = state_q;
      endcase
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (count_q < QFULL) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
        ST_DROP: begin
          if (imem_rvalid) state_d = ST_IDLE;
        end
        default: state_d = state_q;
      endcase

      count_d = count_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      // Only keep requesting while the next word is guaranteed a free slot.
      if (state_q == ST_WAIT && imem_rvalid && !(count_d < QFULL)) state_d = ST_IDLE;
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    if (halt_pend && state_d == ST_IDLE) state_d = ST_HALT;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        instr_q[i] <= '0;
        pc4_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push) begin
        instr_q[wr_ptr_q] <= imem_rdata;
        pc4_q[wr_ptr_q]   <= fetch_pc_q + 32'd4;
      end
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) misalign_q <= 1'b0;
    else          misalign_q <= misalign_d;
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [31:0] dec_pcplus4;
  logic        misalign;

  int checks = 0;
  int failures = 0;

  // Memory model controls
  logic        memAuto = 1'b0;
  int          memDelay = 0;
  logic        autoRvalid = 1'b0;
  logic [31:0] autoRdata = '0;
  logic        manRvalid = 1'b0;
  logic [31:0] manRdata = '0;
  logic        busy = 1'b0;
  int          waitCnt = 0;
  int          curDelay = 0;
  logic [31:0] reqAddr = '0;

  assign imem_rvalid = memAuto ? autoRvalid : manRvalid;
  assign imem_rdata  = memAuto ? autoRdata  : manRdata;

  ifetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .dec_valid(dec_valid),
    .dec_ready(dec_ready),
    .dec_instr(dec_instr),
    .dec_pcplus4(dec_pcplus4),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Memory returns {16'hC0DE, addr[15:0]} curDelay cycles after the first
  // request cycle. A delay of 0 means the data is captured at the next edge.
  always @(posedge clk) begin
    #1;
    autoRvalid = 1'b0;
    if (!memAuto) begin
      busy = 1'b0;
    end else begin
      if (!busy && imem_req) begin
        busy     = 1'b1;
        waitCnt  = 0;
        curDelay = memDelay;
        reqAddr  = imem_addr;
      end
      if (busy) begin
        if (waitCnt == curDelay) begin
          autoRvalid = 1'b1;
          autoRdata  = {16'hC0DE, reqAddr[15:0]};
          busy       = 1'b0;
        end else begin
          waitCnt++;
        end
      end
    end
  end

  task automatic doReset(input logic autoMode);
    @(negedge clk);
    memAuto     = 1'b0;
    reset_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    dec_ready   = 1'b0;
    manRvalid   = 1'b0;
    manRdata    = '0;
    memDelay    = 0;
    repeat (2) @(negedge clk);
    memAuto = autoMode;
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    #1 reset_n = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL rst_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL rst_addr: got %h expected 00000000", imem_addr); end
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid: got %b expected 0", dec_valid); end
    checks++; if (dec_instr !== 32'h0) begin failures++; $display("[TB] FAIL rst_instr: got %h expected 00000000", dec_instr); end
    checks++; if (dec_pcplus4 !== 32'h0) begin failures++; $display("[TB] FAIL rst_pc4: got %h expected 00000000", dec_pcplus4); end
    checks++; if (misalign !== 1'b0) begin failures++; $display("[TB] FAIL rst_misalign: got %b expected 0", misalign); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] expPc4;
    logic [31:0] expInstr;
    doReset(1'b1);
    dec_ready = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL b2b_first_req: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_first_valid: got %b expected 0", dec_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      expPc4   = 32'(4 * (i + 1));
      expInstr = {16'hC0DE, 16'(4 * i)};
      checks++; if (dec_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid[%0d]: got %b expected 1", i, dec_valid); end
      checks++; if (dec_pcplus4 !== expPc4) begin failures++; $display("[TB] FAIL b2b_pc4[%0d]: got %h expected %h", i, dec_pcplus4, expPc4); end
      checks++; if (dec_instr !== expInstr) begin failures++; $display("[TB] FAIL b2b_instr[%0d]: got %h expected %h", i, dec_instr, expInstr); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== expPc4) begin failures++; $display("[TB] FAIL b2b_addr[%0d]: got req=%b addr=%h expected req=1 addr=%h", i, imem_req, imem_addr, expPc4); end
    end
  endtask

  task automatic test_backpressure;
    doReset(1'b1);
    dec_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h8) begin failures++; $display("[TB] FAIL bp_full_req: got req=%b addr=%h expected req=0 addr=00000008", imem_req, imem_addr); end
    checks++; if (dec_valid !== 1'b1 || dec_pcplus4 !== 32'h4 || dec_instr !== 32'hC0DE_0000) begin failures++; $display("[TB] FAIL bp_head0: got v=%b pc4=%h instr=%h expected v=1 pc4=00000004 instr=c0de0000", dec_valid, dec_pcplus4, dec_instr); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h8) begin failures++; $display("[TB] FAIL bp_hold: got req=%b addr=%h expected req=0 addr=00000008", imem_req, imem_addr); end
    dec_ready = 1'b1;
    @(negedge clk);
    checks++; if (dec_valid !== 1'b1 || dec_pcplus4 !== 32'h8 || dec_instr !== 32'hC0DE_0004) begin failures++; $display("[TB] FAIL bp_head1: got v=%b pc4=%h instr=%h expected v=1 pc4=00000008 instr=c0de0004", dec_valid, dec_pcplus4, dec_instr); end
    @(negedge clk);
    checks++; if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("[TB] FAIL bp_resume: got v=%b req=%b addr=%h expected v=0 req=1 addr=00000008", dec_valid, imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (dec_valid !== 1'b1 || dec_pcplus4 !== 32'hC || dec_instr !== 32'hC0DE_0008) begin failures++; $display("[TB] FAIL bp_head2: got v=%b pc4=%h instr=%h expected v=1 pc4=0000000c instr=c0de0008", dec_valid, dec_pcplus4, dec_instr); end
  endtask

  task automatic test_redirect_drop;
    doReset(1'b1);
    dec_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    memDelay = 3;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("[TB] FAIL drop_pending: got req=%b addr=%h expected req=1 addr=00000008", imem_req, imem_addr); end
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    memDelay = 0;
    checks++; if (imem_req !== 1'b0 || dec_valid !== 1'b0 || imem_addr !== 32'h100) begin failures++; $display("[TB] FAIL drop_enter: got req=%b v=%b addr=%h expected req=0 v=0 addr=00000100", imem_req, dec_valid, imem_addr); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL drop_wait: got req=%b expected 0", imem_req); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b0 || dec_valid !== 1'b0) begin failures++; $display("[TB] FAIL drop_discard: got req=%b v=%b expected req=0 v=0", imem_req, dec_valid); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("[TB] FAIL drop_newreq: got req=%b addr=%h expected req=1 addr=00000100", imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (dec_valid !== 1'b1 || dec_pcplus4 !== 32'h104 || dec_instr !== 32'hC0DE_0100) begin failures++; $display("[TB] FAIL drop_newword: got v=%b pc4=%h instr=%h expected v=1 pc4=00000104 instr=c0de0100", dec_valid, dec_pcplus4, dec_instr); end
  endtask

  task automatic test_redirect_full;
    doReset(1'b1);
    dec_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (dec_valid !== 1'b1 || dec_pcplus4 !== 32'h4 || imem_addr !== 32'h4) begin failures++; $display("[TB] FAIL full_pre: got v=%b pc4=%h addr=%h expected v=1 pc4=00000004 addr=00000004", dec_valid, dec_pcplus4, imem_addr); end
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    dec_ready   = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (dec_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h200) begin failures++; $display("[TB] FAIL full_flush: got v=%b req=%b addr=%h expected v=0 req=0 addr=00000200", dec_valid, imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || dec_valid !== 1'b0) begin failures++; $display("[TB] FAIL full_newreq: got req=%b addr=%h v=%b expected req=1 addr=00000200 v=0", imem_req, imem_addr, dec_valid); end
    @(negedge clk);
    checks++; if (dec_valid !== 1'b1 || dec_pcplus4 !== 32'h204 || dec_instr !== 32'hC0DE_0200) begin failures++; $display("[TB] FAIL full_newword: got v=%b pc4=%h instr=%h expected v=1 pc4=00000204 instr=c0de0200", dec_valid, dec_pcplus4, dec_instr); end
  endtask

  task automatic test_reset_mid;
    doReset(1'b0);
    dec_ready = 1'b0;
    @(negedge clk);
    manRvalid = 1'b1;
    manRdata  = 32'h1111_1111;
    @(negedge clk);
    manRvalid = 1'b0;
    checks++; if (dec_valid !== 1'b1 || dec_instr !== 32'h1111_1111 || dec_pcplus4 !== 32'h4 || imem_addr !== 32'h4) begin failures++; $display("[TB] FAIL mid_pre: got v=%b instr=%h pc4=%h addr=%h expected v=1 instr=11111111 pc4=00000004 addr=00000004", dec_valid, dec_instr, dec_pcplus4, imem_addr); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || dec_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_ctl: got req=%b addr=%h v=%b expected req=0 addr=00000000 v=0", imem_req, imem_addr, dec_valid); end
    checks++; if (dec_instr !== 32'h0 || dec_pcplus4 !== 32'h0 || misalign !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_data: got instr=%h pc4=%h mis=%b expected 00000000 00000000 0", dec_instr, dec_pcplus4, misalign); end
    @(negedge clk);
    reset_n   = 1'b1;
    manRvalid = 1'b1;
    manRdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    manRvalid = 1'b0;
    checks++; if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL mid_stale: got v=%b req=%b addr=%h expected v=0 req=1 addr=00000000", dec_valid, imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (dec_valid !== 1'b0 || dec_instr !== 32'h0) begin failures++; $display("[TB] FAIL mid_noword: got v=%b instr=%h expected v=0 instr=00000000", dec_valid, dec_instr); end
  endtask

  task automatic test_misalign;
    doReset(1'b1);
    dec_ready   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h102;
    @(negedge clk);
    redirect = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    checks++; if (misalign !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h102) begin failures++; $display("[TB] FAIL mis_set: got mis=%b req=%b addr=%h expected mis=1 req=0 addr=00000102", misalign, imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b0 || misalign !== 1'b1) begin failures++; $display("[TB] FAIL mis_halt: got req=%b mis=%b expected req=0 mis=1", imem_req, misalign); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b0 || dec_valid !== 1'b0) begin failures++; $display("[TB] FAIL mis_halt2: got req=%b v=%b expected req=0 v=0", imem_req, dec_valid); end
`else
    checks++; if (misalign !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h100) begin failures++; $display("[TB] FAIL mis_align: got mis=%b req=%b addr=%h expected mis=0 req=0 addr=00000100", misalign, imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("[TB] FAIL mis_req: got req=%b addr=%h expected req=1 addr=00000100", imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (dec_valid !== 1'b1 || dec_pcplus4 !== 32'h104 || dec_instr !== 32'hC0DE_0100 || misalign !== 1'b0) begin failures++; $display("[TB] FAIL mis_word: got v=%b pc4=%h instr=%h mis=%b expected v=1 pc4=00000104 instr=c0de0100 mis=0", dec_valid, dec_pcplus4, dec_instr, misalign); end
`endif
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_redirect_drop();
    test_redirect_full();
    test_reset_mid();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
